cache_mem_arbiter: RTL and testbench
====================================

// Module: cache_mem_arbiter
// PURPOSE
// - Shares the single memory port between ICache refill, DCache refill and DCache writeback.
// - Sits between the ICache/DCache miss units and the memory bus.
// - Serialises one line-sized transaction at a time as LINE_WIDTH/BEAT_WIDTH beats.
// - Returns a whole line to the requester that owns the transaction.
// PARAMETERS
// - PLEN        32   physical address width (cfg.PLEN)
// - LINE_WIDTH  128  cache line bits (cfg.ICACHE_LINE_WIDTH == cfg.DCACHE_LINE_WIDTH)
// - BEAT_WIDTH  32   memory data bus bits; LINE_WIDTH % BEAT_WIDTH == 0; BEATS = LINE_WIDTH/BEAT_WIDTH >= 2
// PORTS
// - clk_i            in   1           clock
// - rst_ni           in   1           asynchronous active-low reset
// - ic_req_valid_i   in   1           ICache refill request
// - ic_req_ready_o   out  1           ICache request accepted
// - ic_req_addr_i    in   PLEN        ICache line address
// - ic_kill_i        in   1           ICache flush: suppress pending ICache response
// - ic_rsp_valid_o   out  1           ICache line valid (1-cycle pulse, no back-pressure)
// - ic_rsp_data_o    out  LINE_WIDTH  ICache line data
// - dc_req_valid_i   in   1           DCache refill request
// - dc_req_ready_o   out  1           DCache refill accepted
// - dc_req_addr_i    in   PLEN        DCache refill line address
// - dc_rsp_valid_o   out  1           DCache line valid (1-cycle pulse)
// - dc_rsp_data_o    out  LINE_WIDTH  DCache line data
// - wb_req_valid_i   in   1           DCache writeback request
// - wb_req_ready_o   out  1           writeback accepted (data captured)
// - wb_req_addr_i    in   PLEN        writeback line address
// - wb_req_data_i    in   LINE_WIDTH  writeback line data
// - wb_done_o        out  1           writeback acknowledged by memory (1-cycle pulse)
// - mem_req_valid_o  out  1           memory request/beat valid
// - mem_req_ready_i  in   1           memory accepts request/beat
// - mem_req_we_o     out  1           1 = write beat, 0 = read address
// - mem_req_addr_o   out  PLEN        line address, low $clog2(LINE_WIDTH/8) bits forced 0
// - mem_req_wdata_o  out  BEAT_WIDTH  write beat data
// - mem_req_last_o   out  1           last write beat
// - mem_rsp_valid_i  in   1           read beat / write ack valid
// - mem_rsp_data_i   in   BEAT_WIDTH  read beat data
// BEHAVIOUR
// - Reset: FSM = IDLE; all *_o = 0; beat counter, line buffer and round-robin pointer cleared.
//   Reset asserted mid-transaction aborts it; no response is ever issued for it.
// - States:
//   - IDLE:     arbitrate; the selected requester gets *_req_ready_o = 1 that cycle (addr/data latched).
//               Next state: RD_ADDR (refill) or WR_BEAT (writeback).
//   - RD_ADDR:  mem_req_valid_o = 1, we = 0; on mem_req_ready_i -> RD_DATA.
//   - RD_DATA:  each mem_rsp_valid_i writes beat k into line[k*BEAT_WIDTH +: BEAT_WIDTH], k = 0..BEATS-1.
//               After beat BEATS-1 -> RESP.
//   - WR_BEAT:  mem_req_valid_o = 1, we = 1, wdata = beat k, last = (k == BEATS-1).
//               k advances only on mem_req_ready_i; after the last beat is accepted -> WR_ACK.
//   - WR_ACK:   wait for mem_rsp_valid_i; pulse wb_done_o -> IDLE.
//   - RESP:     pulse the owner's *_rsp_valid_o with the full line -> IDLE.
// - Minimum latency:
//   - Refill: IDLE grant -> response pulse is 2 + BEATS cycles with zero memory stall.
//   - Next grant is possible in the cycle after RESP/WR_ACK.
// - Arbitration priority: wb > dc > ic. wb beats dc so a dirty victim leaves before its set is refilled.
// - Only one ready_o is high per cycle; ready_o is 0 outside IDLE.
// - mem_req_* stay stable while mem_req_valid_o = 1 and mem_req_ready_i = 0.
// - mem_rsp_valid_i outside RD_DATA/WR_ACK is ignored.
// - ic_kill_i:
//   - Asserted in any cycle from ICache grant through RESP (including the RESP cycle itself):
//     a sticky kill flag is set, the memory transaction still completes, and ic_rsp_valid_o is suppressed.
//   - The flag clears on return to IDLE.
//   - ic_kill_i has no effect on DCache/wb transactions.
// - Beat counter width: $clog2(BEATS); it wraps to 0 at transaction end.
// CONFIGURATION
// - ARB_ROUND_ROBIN_EN defined:
//   - wb keeps absolute priority.
//   - dc vs ic uses a 1-bit round-robin pointer that points away from the last granted refill requester.
//   - Ties go to the pointer.
// - ARB_ROUND_ROBIN_EN undefined: fixed priority wb > dc > ic; ic can starve under continuous dc traffic.
// TESTING (PLEN=32, LINE_WIDTH=128, BEAT_WIDTH=32)
// - ic req addr 0x8000_0014, mem beats 0x11,0x22,0x33,0x44 -> mem_req_addr_o = 0x8000_0010;
//   ic_rsp_data_o = 0x00000044_00000033_00000022_00000011, pulse at grant+6.
// - wb, dc and ic valid in the same cycle -> grant order wb, dc, ic.
//   Four write beats, last high on beat 3; wb_done_o after the ack.
// - mem_req_ready_i held 0 for 5 cycles during WR_BEAT k=1 -> wdata/addr/last stable; no beat skipped or duplicated.
// - ic_kill_i pulsed during RD_DATA beat 2 -> all 4 beats consumed, ic_rsp_valid_o stays 0.
//   The next dc request is served normally.
// - rst_ni dropped during RD_DATA beat 1 -> all outputs 0 immediately; no rsp_valid after release.
//   A new ic request completes correctly.
// - ARB_ROUND_ROBIN_EN with dc and ic valid continuously -> grants alternate dc, ic, dc, ic.
//   Without the macro -> dc only.

Source files
------------

// File: rtl/cache_mem_arbiter_if.sv
// Cache-side request/response and memory-side beat bus of the cache memory arbiter.
// The master modport is the arbiter's view; the slave modport is the caches/memory view.
interface cache_mem_arbiter_if #(
  parameter int PLEN       = 32,
  parameter int LINE_WIDTH = 128,
  parameter int BEAT_WIDTH = 32
);
  logic                  ic_req_valid_i;
  logic                  ic_req_ready_o;
  logic [PLEN-1:0]       ic_req_addr_i;
  logic                  ic_kill_i;
  logic                  ic_rsp_valid_o;
  logic [LINE_WIDTH-1:0] ic_rsp_data_o;
  logic                  dc_req_valid_i;
  logic                  dc_req_ready_o;
  logic [PLEN-1:0]       dc_req_addr_i;
  logic                  dc_rsp_valid_o;
  logic [LINE_WIDTH-1:0] dc_rsp_data_o;
  logic                  wb_req_valid_i;
  logic                  wb_req_ready_o;
  logic [PLEN-1:0]       wb_req_addr_i;
  logic [LINE_WIDTH-1:0] wb_req_data_i;
  logic                  wb_done_o;
  logic                  mem_req_valid_o;
  logic                  mem_req_ready_i;
  logic                  mem_req_we_o;
  logic [PLEN-1:0]       mem_req_addr_o;
  logic [BEAT_WIDTH-1:0] mem_req_wdata_o;
  logic                  mem_req_last_o;
  logic                  mem_rsp_valid_i;
  logic [BEAT_WIDTH-1:0] mem_rsp_data_i;

  modport master (
    input  ic_req_valid_i, ic_req_addr_i, ic_kill_i,
    input  dc_req_valid_i, dc_req_addr_i,
    input  wb_req_valid_i, wb_req_addr_i, wb_req_data_i,
    input  mem_req_ready_i, mem_rsp_valid_i, mem_rsp_data_i,
    output ic_req_ready_o, ic_rsp_valid_o, ic_rsp_data_o,
    output dc_req_ready_o, dc_rsp_valid_o, dc_rsp_data_o,
    output wb_req_ready_o, wb_done_o,
    output mem_req_valid_o, mem_req_we_o, mem_req_addr_o, mem_req_wdata_o, mem_req_last_o
  );

  modport slave (
    output ic_req_valid_i, ic_req_addr_i, ic_kill_i,
    output dc_req_valid_i, dc_req_addr_i,
    output wb_req_valid_i, wb_req_addr_i, wb_req_data_i,
    output mem_req_ready_i, mem_rsp_valid_i, mem_rsp_data_i,
    input  ic_req_ready_o, ic_rsp_valid_o, ic_rsp_data_o,
    input  dc_req_ready_o, dc_rsp_valid_o, dc_rsp_data_o,
    input  wb_req_ready_o, wb_done_o,
    input  mem_req_valid_o, mem_req_we_o, mem_req_addr_o, mem_req_wdata_o, mem_req_last_o
  );
endinterface

// File: rtl/cache_mem_arbiter.sv
// Shares one memory port between ICache refill, DCache refill and DCache writeback (ARB_ROUND_ROBIN_EN: dc/ic round-robin).
// Refill grant-to-response 2+BEATS cycles unstalled; mem_req_* held while ready is low; responses are unstallable pulses.
module cache_mem_arbiter #(
  parameter int PLEN       = 32,
  parameter int LINE_WIDTH = 128,
  parameter int BEAT_WIDTH = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  cache_mem_arbiter_if.master  bus
);
  localparam int BEATS = LINE_WIDTH / BEAT_WIDTH;
  localparam int CNT_W = $clog2(BEATS);
  localparam int OFF_W = $clog2(LINE_WIDTH / 8);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

  typedef enum logic [2:0] {S_IDLE, S_RD_ADDR, S_RD_DATA, S_WR_BEAT, S_WR_ACK, S_RESP} state_t;
  typedef enum logic [1:0] {OWN_IC, OWN_DC, OWN_WB} owner_t;

  state_t                           r_state, w_state_nxt;
  owner_t                           r_owner;
  logic [CNT_W-1:0]                 r_beat;
  logic [BEATS-1:0][BEAT_WIDTH-1:0] r_line;
  logic [PLEN-1:0]                  r_addr;
  logic                             r_kill;
  logic                             w_gnt_wb, w_gnt_dc, w_gnt_ic, w_pick_ic;
  logic [PLEN-1:0]                  w_raw_addr;
  logic                             w_mem_vld, w_mem_we, w_mem_last;
  logic                             w_wb_done, w_ic_rsp, w_dc_rsp;
  logic                             w_last_beat;

`ifdef ARB_ROUND_ROBIN_EN
  logic r_rr_ptr;  // 1 = ic preferred on a dc/ic tie

  assign w_pick_ic = bus.ic_req_valid_i && (!bus.dc_req_valid_i || r_rr_ptr);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)       r_rr_ptr <= 1'b0;
    else if (w_gnt_dc) r_rr_ptr <= 1'b1;
    else if (w_gnt_ic) r_rr_ptr <= 1'b0;
  end
`else
  assign w_pick_ic = bus.ic_req_valid_i && !bus.dc_req_valid_i;
`endif

  always_comb begin
    w_gnt_wb = 1'b0;
    w_gnt_dc = 1'b0;
    w_gnt_ic = 1'b0;
    if (r_state == S_IDLE && rst_ni) begin
      if (bus.wb_req_valid_i)      w_gnt_wb = 1'b1;
      else if (w_pick_ic)          w_gnt_ic = 1'b1;
      else if (bus.dc_req_valid_i) w_gnt_dc = 1'b1;
    end
  end

  always_comb begin
    w_raw_addr = bus.ic_req_addr_i;
    if (w_gnt_wb)      w_raw_addr = bus.wb_req_addr_i;
    else if (w_gnt_dc) w_raw_addr = bus.dc_req_addr_i;
  end

  assign w_last_beat = (r_beat == LAST_BEAT);

  always_comb begin
    w_state_nxt = r_state;
    w_mem_vld   = 1'b0;
    w_mem_we    = 1'b0;
    w_mem_last  = 1'b0;
    w_wb_done   = 1'b0;
    w_ic_rsp    = 1'b0;
    w_dc_rsp    = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (w_gnt_wb)                  w_state_nxt = S_WR_BEAT;
        else if (w_gnt_dc || w_gnt_ic) w_state_nxt = S_RD_ADDR;
      end
      S_RD_ADDR: begin
        w_mem_vld = 1'b1;
        if (bus.mem_req_ready_i) w_state_nxt = S_RD_DATA;
      end
      S_RD_DATA: begin
        if (bus.mem_rsp_valid_i && w_last_beat) w_state_nxt = S_RESP;
      end
      S_WR_BEAT: begin
        w_mem_vld  = 1'b1;
        w_mem_we   = 1'b1;
        w_mem_last = w_last_beat;
        if (bus.mem_req_ready_i && w_last_beat) w_state_nxt = S_WR_ACK;
      end
      S_WR_ACK: begin
        if (bus.mem_rsp_valid_i) begin
          w_wb_done   = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      S_RESP: begin
        // A kill in the response cycle itself must still suppress the pulse.
        w_ic_rsp    = (r_owner == OWN_IC) && !r_kill && !bus.ic_kill_i;
        w_dc_rsp    = (r_owner == OWN_DC);
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= S_IDLE;
      r_owner <= OWN_IC;
      r_beat  <= '0;
      r_line  <= '0;
      r_addr  <= '0;
      r_kill  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == S_IDLE) begin
        r_kill <= w_gnt_ic && bus.ic_kill_i;
        if (w_gnt_wb || w_gnt_dc || w_gnt_ic) begin
          r_addr <= {w_raw_addr[PLEN-1:OFF_W], {OFF_W{1'b0}}};
        end
        if (w_gnt_wb) begin
          r_owner <= OWN_WB;
          r_line  <= bus.wb_req_data_i;
        end else if (w_gnt_dc) begin
          r_owner <= OWN_DC;
        end else if (w_gnt_ic) begin
          r_owner <= OWN_IC;
        end
      end else if (r_owner == OWN_IC && bus.ic_kill_i) begin
        r_kill <= 1'b1;
      end
      if (r_state == S_RD_DATA && bus.mem_rsp_valid_i) begin
        r_line[r_beat] <= bus.mem_rsp_data_i;
        r_beat         <= w_last_beat ? '0 : r_beat + 1'b1;
      end
      if (r_state == S_WR_BEAT && bus.mem_req_ready_i) begin
        r_beat <= w_last_beat ? '0 : r_beat + 1'b1;
      end
    end
  end

  assign bus.ic_req_ready_o  = w_gnt_ic;
  assign bus.dc_req_ready_o  = w_gnt_dc;
  assign bus.wb_req_ready_o  = w_gnt_wb;
  assign bus.ic_rsp_valid_o  = w_ic_rsp;
  assign bus.dc_rsp_valid_o  = w_dc_rsp;
  assign bus.ic_rsp_data_o   = w_ic_rsp ? r_line : '0;
  assign bus.dc_rsp_data_o   = w_dc_rsp ? r_line : '0;
  assign bus.wb_done_o       = w_wb_done;
  assign bus.mem_req_valid_o = w_mem_vld;
  assign bus.mem_req_we_o    = w_mem_we;
  assign bus.mem_req_last_o  = w_mem_last;
  assign bus.mem_req_addr_o  = w_mem_vld ? r_addr : '0;
  assign bus.mem_req_wdata_o = w_mem_we ? r_line[r_beat] : '0;
endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Directed bench for cache_mem_arbiter: refill, writeback, stalls, kill, reset abort, arbitration order.
// Inputs change 2 time units after the rising edge; outputs are checked one unit later.
module tb_cache_mem_arbiter;
  logic clk_i = 1'b0;
  logic rst_ni;
  int   n_chk = 0;
  int   n_err = 0;
  logic rr_mode;
  logic exp_ic;

  always #5 clk_i = ~clk_i;

  cache_mem_arbiter_if #(.PLEN(32), .LINE_WIDTH(128), .BEAT_WIDTH(32)) bus ();

  cache_mem_arbiter #(.PLEN(32), .LINE_WIDTH(128), .BEAT_WIDTH(32)) dut (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .bus    (bus)
  );

  task automatic cyc();
    @(posedge clk_i);
    #2;
  endtask

  task automatic chk_b(input string tag, input logic obs, input logic exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk_w(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_l(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Called in the grant cycle; returns in the RESP cycle with inputs settled.
  task automatic serve_read(input logic [31:0] base, input logic [31:0] exp_addr, input int kill_beat);
    cyc();
    bus.mem_req_ready_i = 1'b1;
    #1;
    chk_b("rd_addr_vld", bus.mem_req_valid_o, 1'b1);
    chk_b("rd_addr_we", bus.mem_req_we_o, 1'b0);
    chk_w("rd_addr", bus.mem_req_addr_o, exp_addr);
    chk_b("rd_addr_no_rdy", bus.ic_req_ready_o | bus.dc_req_ready_o | bus.wb_req_ready_o, 1'b0);
    for (int k = 0; k < 4; k++) begin
      cyc();
      bus.mem_req_ready_i = 1'b0;
      bus.mem_rsp_valid_i = 1'b1;
      bus.mem_rsp_data_i  = base * (k + 1);
      bus.ic_kill_i       = (k == kill_beat);
      #1;
      chk_b("rd_no_early_rsp", bus.ic_rsp_valid_o | bus.dc_rsp_valid_o, 1'b0);
    end
    cyc();
    bus.mem_rsp_valid_i = 1'b0;
    bus.mem_rsp_data_i  = '0;
    bus.ic_kill_i       = 1'b0;
    #1;
  endtask

  initial begin
`ifdef ARB_ROUND_ROBIN_EN
    rr_mode = 1'b1;
`else
    rr_mode = 1'b0;
`endif
    rst_ni              = 1'b0;
    bus.ic_req_valid_i  = 1'b0;
    bus.ic_req_addr_i   = '0;
    bus.ic_kill_i       = 1'b0;
    bus.dc_req_valid_i  = 1'b0;
    bus.dc_req_addr_i   = '0;
    bus.wb_req_valid_i  = 1'b0;
    bus.wb_req_addr_i   = '0;
    bus.wb_req_data_i   = '0;
    bus.mem_req_ready_i = 1'b0;
    bus.mem_rsp_valid_i = 1'b0;
    bus.mem_rsp_data_i  = '0;

    // Reset state
    repeat (2) cyc();
    #1;
    chk_b("rst_mem_vld", bus.mem_req_valid_o, 1'b0);
    chk_w("rst_mem_addr", bus.mem_req_addr_o, 32'h0);
    chk_b("rst_ic_rdy", bus.ic_req_ready_o, 1'b0);
    chk_b("rst_ic_rsp", bus.ic_rsp_valid_o, 1'b0);
    chk_b("rst_wb_done", bus.wb_done_o, 1'b0);
    chk_l("rst_dc_data", bus.dc_rsp_data_o, 128'h0);
    rst_ni = 1'b1;
    cyc();

    // ICache refill, unaligned address, zero memory stall
    bus.ic_req_valid_i = 1'b1;
    bus.ic_req_addr_i  = 32'h8000_0014;
    #1;
    chk_b("t1_ic_rdy", bus.ic_req_ready_o, 1'b1);
    chk_b("t1_dc_rdy", bus.dc_req_ready_o, 1'b0);
    serve_read(32'h11, 32'h8000_0010, -1);
    bus.ic_req_valid_i = 1'b0;
    chk_b("t1_ic_rsp", bus.ic_rsp_valid_o, 1'b1);
    chk_l("t1_ic_data", bus.ic_rsp_data_o, 128'h00000044_00000033_00000022_00000011);
    cyc();
    #1;
    chk_b("t1_pulse_end", bus.ic_rsp_valid_o, 1'b0);

    // wb, dc and ic simultaneously
    bus.wb_req_valid_i = 1'b1;
    bus.wb_req_addr_i  = 32'h0000_1234;
    bus.wb_req_data_i  = 128'hDDDD0003_CCCC0002_BBBB0001_AAAA0000;
    bus.dc_req_valid_i = 1'b1;
    bus.dc_req_addr_i  = 32'h2000_0048;
    bus.ic_req_valid_i = 1'b1;
    bus.ic_req_addr_i  = 32'h3000_0004;
    #1;
    chk_b("t2_wb_rdy", bus.wb_req_ready_o, 1'b1);
    chk_b("t2_dc_rdy0", bus.dc_req_ready_o, 1'b0);
    chk_b("t2_ic_rdy0", bus.ic_req_ready_o, 1'b0);
    cyc();
    bus.wb_req_valid_i  = 1'b0;
    bus.mem_req_ready_i = 1'b1;
    #1;
    chk_b("t2_wr_we", bus.mem_req_we_o, 1'b1);
    chk_w("t2_wr_addr", bus.mem_req_addr_o, 32'h0000_1230);
    chk_w("t2_wr_b0", bus.mem_req_wdata_o, 32'hAAAA_0000);
    chk_b("t2_wr_last0", bus.mem_req_last_o, 1'b0);
    chk_b("t2_dc_blocked", bus.dc_req_ready_o, 1'b0);
    cyc();
    bus.mem_req_ready_i = 1'b0;
    for (int s = 0; s < 5; s++) begin
      #1;
      chk_b("t2_stall_vld", bus.mem_req_valid_o, 1'b1);
      chk_w("t2_stall_b1", bus.mem_req_wdata_o, 32'hBBBB_0001);
      chk_w("t2_stall_addr", bus.mem_req_addr_o, 32'h0000_1230);
      chk_b("t2_stall_last", bus.mem_req_last_o, 1'b0);
      cyc();
    end
    bus.mem_req_ready_i = 1'b1;
    #1;
    chk_w("t2_wr_b1", bus.mem_req_wdata_o, 32'hBBBB_0001);
    cyc();
    #1;
    chk_w("t2_wr_b2", bus.mem_req_wdata_o, 32'hCCCC_0002);
    chk_b("t2_wr_last2", bus.mem_req_last_o, 1'b0);
    cyc();
    #1;
    chk_w("t2_wr_b3", bus.mem_req_wdata_o, 32'hDDDD_0003);
    chk_b("t2_wr_last3", bus.mem_req_last_o, 1'b1);
    cyc();
    bus.mem_req_ready_i = 1'b0;
    #1;
    chk_b("t2_ack_no_vld", bus.mem_req_valid_o, 1'b0);
    chk_b("t2_ack_wait", bus.wb_done_o, 1'b0);
    cyc();
    bus.mem_rsp_valid_i = 1'b1;
    #1;
    chk_b("t2_wb_done", bus.wb_done_o, 1'b1);
    cyc();
    bus.mem_rsp_valid_i = 1'b0;
    #1;
    chk_b("t2_wb_done_end", bus.wb_done_o, 1'b0);
    chk_b("t2_dc_rdy", bus.dc_req_ready_o, 1'b1);
    chk_b("t2_ic_wait", bus.ic_req_ready_o, 1'b0);
    serve_read(32'h100, 32'h2000_0040, -1);
    bus.dc_req_valid_i = 1'b0;
    chk_b("t2_dc_rsp", bus.dc_rsp_valid_o, 1'b1);
    chk_b("t2_dc_not_ic", bus.ic_rsp_valid_o, 1'b0);
    chk_l("t2_dc_data", bus.dc_rsp_data_o, 128'h00000400_00000300_00000200_00000100);
    cyc();
    #1;
    chk_b("t2_ic_rdy", bus.ic_req_ready_o, 1'b1);
    serve_read(32'h7, 32'h3000_0000, -1);
    bus.ic_req_valid_i = 1'b0;
    chk_b("t2_ic_rsp", bus.ic_rsp_valid_o, 1'b1);
    chk_l("t2_ic_data", bus.ic_rsp_data_o, 128'h0000001C_00000015_0000000E_00000007);
    cyc();

    // ic_kill_i during read beat 2
    bus.ic_req_valid_i = 1'b1;
    bus.ic_req_addr_i  = 32'h4000_0000;
    #1;
    chk_b("t3_ic_rdy", bus.ic_req_ready_o, 1'b1);
    serve_read(32'h55, 32'h4000_0000, 2);
    bus.ic_req_valid_i = 1'b0;
    chk_b("t3_killed_rsp", bus.ic_rsp_valid_o, 1'b0);
    chk_b("t3_resp_no_mem", bus.mem_req_valid_o, 1'b0);
    cyc();
    bus.dc_req_valid_i = 1'b1;
    bus.dc_req_addr_i  = 32'h5000_0020;
    #1;
    chk_b("t3_dc_rdy", bus.dc_req_ready_o, 1'b1);
    serve_read(32'h1000, 32'h5000_0020, -1);
    bus.dc_req_valid_i = 1'b0;
    chk_b("t3_dc_rsp", bus.dc_rsp_valid_o, 1'b1);
    chk_l("t3_dc_data", bus.dc_rsp_data_o, 128'h00004000_00003000_00002000_00001000);
    cyc();

    // Reset during read beat 1
    bus.ic_req_valid_i = 1'b1;
    bus.ic_req_addr_i  = 32'h6000_0000;
    #1;
    chk_b("t4_ic_rdy", bus.ic_req_ready_o, 1'b1);
    cyc();
    bus.ic_req_valid_i  = 1'b0;
    bus.mem_req_ready_i = 1'b1;
    cyc();
    bus.mem_req_ready_i = 1'b0;
    bus.mem_rsp_valid_i = 1'b1;
    bus.mem_rsp_data_i  = 32'hAA;
    cyc();
    bus.mem_rsp_data_i  = 32'hBB;
    #1;
    rst_ni = 1'b0;
    #1;
    chk_b("t4_rst_mem_vld", bus.mem_req_valid_o, 1'b0);
    chk_b("t4_rst_ic_rsp", bus.ic_rsp_valid_o, 1'b0);
    chk_b("t4_rst_ic_rdy", bus.ic_req_ready_o, 1'b0);
    chk_l("t4_rst_ic_data", bus.ic_rsp_data_o, 128'h0);
    bus.mem_rsp_valid_i = 1'b0;
    cyc();
    cyc();
    rst_ni = 1'b1;
    for (int s = 0; s < 4; s++) begin
      bus.mem_rsp_valid_i = 1'b1;
      bus.mem_rsp_data_i  = 32'hEE;
      #1;
      chk_b("t4_no_rsp_after", bus.ic_rsp_valid_o, 1'b0);
      chk_b("t4_no_mem_after", bus.mem_req_valid_o, 1'b0);
      cyc();
    end
    bus.mem_rsp_valid_i = 1'b0;
    bus.mem_rsp_data_i  = '0;
    bus.ic_req_valid_i  = 1'b1;
    bus.ic_req_addr_i   = 32'h6000_0040;
    #1;
    chk_b("t4_new_rdy", bus.ic_req_ready_o, 1'b1);
    serve_read(32'h9, 32'h6000_0040, -1);
    bus.ic_req_valid_i = 1'b0;
    chk_b("t4_new_rsp", bus.ic_rsp_valid_o, 1'b1);
    chk_l("t4_new_data", bus.ic_rsp_data_o, 128'h00000024_0000001B_00000012_00000009);
    cyc();

    // dc and ic held valid continuously
    bus.dc_req_valid_i = 1'b1;
    bus.dc_req_addr_i  = 32'h7000_0000;
    bus.ic_req_valid_i = 1'b1;
    bus.ic_req_addr_i  = 32'h7100_0000;
    for (int i = 0; i < 4; i++) begin
      exp_ic = rr_mode && (i % 2 == 1);
      #1;
      chk_b("t5_grant_dc", bus.dc_req_ready_o, !exp_ic);
      chk_b("t5_grant_ic", bus.ic_req_ready_o, exp_ic);
      serve_read(32'h20 + i, exp_ic ? 32'h7100_0000 : 32'h7000_0000, -1);
      chk_b("t5_rsp_dc", bus.dc_rsp_valid_o, !exp_ic);
      chk_b("t5_rsp_ic", bus.ic_rsp_valid_o, exp_ic);
      cyc();
    end
    bus.dc_req_valid_i = 1'b0;
    bus.ic_req_valid_i = 1'b0;
    cyc();

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
